// File: rtl/cpu_pkg.sv
// Shared constants for the five-stage MIPS pipeline: reset vector, bubble word,
// opcode/funct codes and the PCSrc encoding used by fetch and the control decoder.
package cpu_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [15:0] FLUSH_MAX = 16'hFFFF;

    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    typedef enum logic [1:0] {
        PCSRC_SEQ    = 2'b00,
        PCSRC_JUMP   = 2'b01,
        PCSRC_JR     = 2'b10,
        PCSRC_BRANCH = 2'b11
    } pcsrc_t;

    // Instruction addresses are word aligned; target low bits carry no meaning.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: EX branch, then stall hold, then ID jr, then ID jump,
// then sequential. Also reports whether IF/ID must hold or be squashed.
module pc_next_sel
    import cpu_pkg::*;
(
    input  logic        stall,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] pc_plus4,
    output logic [31:0] pc_next,
    output logic        hold,
    output logic        flush_if
);

    pcsrc_t pc_src;

    always_comb begin
        pc_src   = PCSRC_SEQ;
        hold     = 1'b0;
        flush_if = 1'b0;
        if (branch_taken) begin
            pc_src   = PCSRC_BRANCH;
            flush_if = 1'b1;
        end else if (stall) begin
            hold     = 1'b1;
        end else if (jr_en) begin
            pc_src   = PCSRC_JR;
            flush_if = 1'b1;
        end else if (jump_en) begin
            pc_src   = PCSRC_JUMP;
            flush_if = 1'b1;
        end
    end

    always_comb begin
        pc_next = align_word(pc_plus4);
        case (pc_src)
            PCSRC_JUMP:   pc_next = align_word(jump_target);
            PCSRC_JR:     pc_next = align_word(jr_target);
            PCSRC_BRANCH: pc_next = align_word(branch_target);
            default:      pc_next = align_word(pc_plus4);
        endcase
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a saturating
// count of fetches squashed by control-flow redirects.
module if_fetch_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic [5:0]  id_opcode,
    output logic [5:0]  id_funct,
    output logic [15:0] flush_count
);

    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        hold;
    logic        flush_if;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign id_opcode = id_instr[31:26];
    assign id_funct  = id_instr[5:0];

    pc_next_sel u_pc_next_sel (
        .stall         (stall),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .jr_en         (jr_en),
        .jr_target     (jr_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_plus4      (pc_plus4),
        .pc_next       (pc_next),
        .hold          (hold),
        .flush_if      (flush_if)
    );

    // A redirect replaces the wrong-path fetch with a bubble; stall freezes everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_instr    <= NOP_WORD;
            id_pc_plus4 <= 32'h0;
            flush_count <= 16'h0;
        end else if (!hold) begin
            pc <= pc_next;
            if (flush_if) begin
                id_valid    <= 1'b0;
                id_instr    <= NOP_WORD;
                id_pc_plus4 <= 32'h0;
                if (flush_count != FLUSH_MAX) begin
                    flush_count <= flush_count + 16'd1;
                end
            end else begin
                id_valid    <= 1'b1;
                id_instr    <= imem_rdata;
                id_pc_plus4 <= pc_plus4;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus random redirects
// and stalls, compared against a behavioural PC/IF-ID model.
module tb_if_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        jump_en;
    logic [31:0] jump_target;
    logic        jr_en;
    logic [31:0] jr_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [15:0] flush_count;

    int vectors;
    int miscompares;

    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    int          m_flushes;

    if_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .jr_en         (jr_en),
        .jr_target     (jr_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc_plus4   (id_pc_plus4),
        .id_opcode     (id_opcode),
        .id_funct      (id_funct),
        .flush_count   (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        if (addr == 32'h0040_0000) return 32'h2008_0005;
        if (addr == 32'h0040_0004) return 32'h2009_0003;
        return (addr * 32'h9E37_79B9) ^ 32'h0F0F_1234;
    endfunction

    always_comb imem_rdata = rom_word(imem_addr);

    task automatic model_reset();
        m_pc      = 32'h0040_0000;
        m_valid   = 1'b0;
        m_instr   = 32'h0;
        m_pc4     = 32'h0;
        m_flushes = 0;
    endtask

    task automatic model_bubble(input logic [31:0] target);
        m_pc      = target & 32'hFFFF_FFFC;
        m_valid   = 1'b0;
        m_instr   = 32'h0;
        m_pc4     = 32'h0;
        m_flushes = m_flushes + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [31:0] exp_fc;
        exp_fc = (m_flushes > 65535) ? 32'hFFFF : 32'(m_flushes);
        check("pc",          pc,                  m_pc);
        check("imem_addr",   imem_addr,           m_pc);
        check("id_valid",    {31'b0, id_valid},   {31'b0, m_valid});
        check("id_instr",    id_instr,            m_instr);
        check("id_pc_plus4", id_pc_plus4,         m_pc4);
        check("id_opcode",   {26'b0, id_opcode},  {26'b0, m_instr[31:26]});
        check("id_funct",    {26'b0, id_funct},   {26'b0, m_instr[5:0]});
        check("flush_count", {16'b0, flush_count}, exp_fc);
    endtask

    // One clock edge with the given controls; the model follows the priority rules.
    task automatic applyStimulus(input logic s, input logic j, input logic [31:0] jt,
                                 input logic r, input logic [31:0] rt,
                                 input logic b, input logic [31:0] bt,
                                 input bit do_check);
        stall = s; jump_en = j; jump_target = jt;
        jr_en = r; jr_target = rt; branch_taken = b; branch_target = bt;
        @(posedge clk);
        #1;
        if (b)      model_bubble(bt);
        else if (s) begin end
        else if (r) model_bubble(rt);
        else if (j) model_bubble(jt);
        else begin
            m_valid = 1'b1;
            m_instr = rom_word(m_pc);
            m_pc4   = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
        end
        stall = 0; jump_en = 0; jr_en = 0; branch_taken = 0;
        if (do_check) checkOutput();
    endtask

    task automatic seq_step();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1'b1);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        stall = 0; jump_en = 0; jr_en = 0; branch_taken = 0;
        jump_target = 0; jr_target = 0; branch_target = 0;
        model_reset();
        #12;
        checkOutput();
        reset = 1'b0;
        checkOutput();

        seq_step();
        seq_step();

        applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1'b1);
        applyStimulus(1, 1, 32'h0040_0100, 0, 32'h0, 0, 32'h0, 1'b1);
        seq_step();

        applyStimulus(0, 1, 32'h0040_0040, 0, 32'h0, 0, 32'h0, 1'b1);
        seq_step();

        applyStimulus(1, 1, 32'h0040_0080, 0, 32'h0, 1, 32'h0040_0020, 1'b1);
        seq_step();
        seq_step();

        applyStimulus(0, 0, 32'h0, 1, 32'h1234_5677, 0, 32'h0, 1'b1);
        seq_step();
        applyStimulus(0, 1, 32'h0040_0200, 1, 32'h0040_0300, 0, 32'h0, 1'b1);

        applyStimulus(0, 0, 32'h0, 1, 32'hFFFF_FFFF, 0, 32'h0, 1'b1);
        seq_step();
        seq_step();

        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), $urandom,
                          ($urandom_range(0, 7) == 0), $urandom,
                          ($urandom_range(0, 7) == 0), $urandom, 1'b1);
        end

        applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1'b1);
        stall = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        checkOutput();
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        seq_step();

        for (int i = 0; i < 65540; i++) begin
            applyStimulus(0, 1, 32'h0040_1000 + 32'(i[7:0]) * 4, 0, 32'h0, 0, 32'h0, 1'b0);
        end
        checkOutput();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 32'h0040_0800, 1'b1);
        seq_step();

        jr_en = 1'b1;
        jr_target = 32'h0050_0000;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        checkOutput();
        @(negedge clk);
        reset = 1'b0;
        jr_en = 1'b0;
        seq_step();
        seq_step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS pipeline. Holds the PC, drives the instruction-memory address, selects the next PC from sequential, jump, jump-register and branch redirects, and registers the fetched word into IF/ID. Its registered outputs feed the ID stage directly: `id_opcode`/`id_funct` drive the control decoder, and `id_pc_plus4` feeds jump/branch target and link-address formation.

## Interface
- `RESET_PC`, 32'h0040_0000, PC value loaded on reset
- `NOP_WORD`, 32'h0000_0000, instruction word inserted as a bubble (`sll $0,$0,0`)

- `clk`  in  1  pipeline clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `stall`  in  1  load-use hold from hazard unit
- `jump_en`  in  1  ID-stage `j`/`jal` (PCSrc = 01)
- `jump_target`  in  32  `{id_pc_plus4[31:28], instr[25:0], 2'b00}`
- `jr_en`  in  1  ID-stage `jr`/`jalr` (PCSrc = 10)
- `jr_target`  in  32  forwarded rs value
- `branch_taken`  in  1  EX-stage resolved taken `beq`
- `branch_target`  in  32  EX-stage branch target
- `imem_addr`  out  32  current PC; combinational ROM address
- `imem_rdata`  in  32  instruction at `imem_addr`, same cycle
- `pc`  out  32  current PC (debug)
- `id_valid`  out  1  IF/ID holds a real instruction
- `id_instr`  out  32  IF/ID instruction
- `id_pc_plus4`  out  32  IF/ID PC+4
- `id_opcode`  out  6  `id_instr[31:26]`
- `id_funct`  out  6  `id_instr[5:0]`
- `flush_count`  out  16  saturating count of squashed fetches

## Operation
- Reset (async, any time, including mid-stall or mid-redirect): `pc`=RESET_PC, `id_valid`=0, `id_instr`=NOP_WORD, `id_pc_plus4`=0, `flush_count`=0.
- Next-PC priority, highest first:
  - `branch_taken` → `branch_target`; IF/ID ← bubble. Wins over stall and ID redirects (ID holds wrong-path instruction).
  - `stall` → PC and IF/ID hold. `jump_en`/`jr_en` ignored while stalled.
  - `jr_en` → `jr_target`; IF/ID ← bubble.
  - `jump_en` → `jump_target`; IF/ID ← bubble.
  - else → PC+4; IF/ID ← {1, `imem_rdata`, PC+4}.
- `jr_en` and `jump_en` both high is illegal; `jr_en` wins.
- Bubble: `id_valid`=0, `id_instr`=NOP_WORD, `id_pc_plus4`=0.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. PC[1:0] forced 00 on every load; low bits of targets are discarded.
- `flush_count` increments by 1 on every edge that loads a bubble due to a redirect (not stall, not reset); saturates at 16'hFFFF.
- `id_opcode`/`id_funct` are pure slices of `id_instr`; a bubble decodes as R-type `sll`, funct 0.

## Timing
- Fetch latency 1 cycle: `imem_rdata` at cycle n appears on `id_instr` after edge n.
- Redirect sampled at edge n; the target address is on `imem_addr` in cycle n+1. The target instruction reaches ID after edge n+1.
- Jump/jr penalty: 1 bubble. Branch penalty: 2 bubbles. This block squashes IF/ID; the ID/EX squash belongs to the hazard unit.
- Stall of k cycles holds `pc` and all `id_*` outputs unchanged for k edges. No instruction is lost or duplicated.
- All outputs are registered except `imem_addr` (= `pc`) and the opcode/funct slices.

## Structure
- `cpu_pkg`: RESET_PC, NOP_WORD, opcode/funct constants (J=6'h02, JAL=6'h03, BEQ=6'h04, JR=6'h08, JALR=6'h09), and the PCSrc encoding shared with the control decoder.
- One sub-module, `pc_next_sel`: combinational priority mux that produces `pc_next` and `flush_if`. The PC register, IF/ID register and counter live in the top module.

## Test plan
- Reset release with ROM words 0x2008_0005 and 0x2009_0003 → `imem_addr` 0x0040_0000, then 0x0040_0004; `id_instr`=0x2008_0005 with `id_valid`=1 after the first edge, `id_pc_plus4`=0x0040_0004.
- Sequential fetch with a 2-cycle `stall` at PC 0x0040_0008 → PC holds 0x0040_0008 for 2 edges; `id_*` unchanged; `flush_count` stays 0.
- `jump_en`, target 0x0040_0040 → next `imem_addr` 0x0040_0040; one bubble (`id_valid`=0, `id_instr`=0); `flush_count`=1.
- `branch_taken` (target 0x0040_0020) with `stall`=1 and `jump_en`=1 in the same cycle → PC=0x0040_0020, IF/ID bubble; branch wins.
- `jr_en`, target 0x1234_5677 → PC=0x1234_5674. Separately, PC 0xFFFF_FFFC sequential → PC wraps to 0x0000_0000.
- Assert `reset` mid-stall, and `flush_count` preloaded at 0xFFFF plus a redirect → outputs return to reset values immediately (asynchronous); saturated counter stays at 0xFFFF.
